// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter merging NUM_STREAMS AXI streams onto one output.
// A grant is held for a whole packet; the data path is a combinational mux of the granted input.
module axis_packet_arbiter #(
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned NUM_STREAMS    = 2,
  localparam int unsigned IDX_W         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
  localparam int unsigned DATA_W        = AXIS_BYTES * 8
) (
  input  logic                                 clk,
  input  logic                                 sresetn,
  output logic [NUM_STREAMS-1:0]               axis_i_tready,
  input  logic [NUM_STREAMS-1:0]               axis_i_tvalid,
  input  logic [NUM_STREAMS-1:0]               axis_i_tlast,
  input  logic [NUM_STREAMS*DATA_W-1:0]        axis_i_tdata,
  input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                                 axis_o_tready,
  output logic                                 axis_o_tvalid,
  output logic                                 axis_o_tlast,
  output logic [DATA_W-1:0]                    axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic                                 grant_valid,
  output logic [IDX_W-1:0]                     grant_index
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] pointer_next;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             packet_done;

  logic [NUM_STREAMS-1:0][DATA_W-1:0]         in_data;
  logic [NUM_STREAMS-1:0][AXIS_USER_BITS-1:0] in_user;

  assign in_data = axis_i_tdata;
  assign in_user = axis_i_tuser;

  // First valid requester at or after the priority pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      cand_idx = IDX_W'((32'(pointer) + k) % NUM_STREAMS);
      if (!pick_found && axis_i_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Output mux and ready steering; idle outputs whenever no packet is locked.
  always_comb begin
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    axis_o_tuser  = '0;
    axis_i_tready = '0;
    if (state == LOCKED) begin
      axis_o_tvalid              = axis_i_tvalid[grant_index];
      axis_o_tlast               = axis_i_tlast[grant_index];
      axis_o_tdata               = in_data[grant_index];
      axis_o_tuser               = in_user[grant_index];
      axis_i_tready[grant_index] = axis_o_tready;
    end
  end

  assign packet_done  = axis_o_tvalid && axis_o_tready && axis_o_tlast;
  assign pointer_next = IDX_W'((32'(grant_index) + 32'd1) % NUM_STREAMS);
  assign grant_valid  = (state == LOCKED);

  // Grant FSM: arbitrate in IDLE, hold the grant until the tlast handshake.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state       <= IDLE;
      grant_index <= '0;
      pointer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_index <= pick_idx;
            state       <= LOCKED;
          end
        end
        LOCKED: begin
          if (packet_done) begin
            pointer <= pointer_next;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 streams): per-stream source queues drive the
// inputs, a monitor pops an expected-beat scoreboard on every output handshake.
module tb_axis_packet_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [1:0] s;
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic sresetn;
  logic [NS-1:0]   in_tready;
  logic [NS-1:0]   in_tvalid;
  logic [NS-1:0]   in_tlast;
  logic [NS*8-1:0] in_tdata;
  logic [NS-1:0]   in_tuser;
  logic            o_tready;
  logic            o_tvalid;
  logic            o_tlast;
  logic [7:0]      o_tdata;
  logic            o_tuser;
  logic            grant_valid;
  logic [IW-1:0]   grant_index;

  beat_t       src_q [NS][$];
  beat_t       exp_q [$];
  logic [NS-1:0] hold;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .AXIS_BYTES    (1),
    .AXIS_USER_BITS(1),
    .NUM_STREAMS   (NS)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .axis_i_tready(in_tready),
    .axis_i_tvalid(in_tvalid),
    .axis_i_tlast (in_tlast),
    .axis_i_tdata (in_tdata),
    .axis_i_tuser (in_tuser),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata),
    .axis_o_tuser (o_tuser),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk(input int s, input logic [7:0] d, input logic l);
    beat_t b;
    b.s = 2'(s);
    b.d = d;
    b.u = ^d;
    b.l = l;
    return b;
  endfunction

  task automatic src_pkt(input int s, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < n; k++) src_q[s].push_back(mk(s, base + 8'(k) * step, k == n - 1));
  endtask

  task automatic exp_pkt(input int s, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(s, base + 8'(k) * step, k == n - 1));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) cyc();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    sresetn = 1'b0;
    cyc();
    cyc();
    sresetn = 1'b1;
  endtask

  // Sources: pop on the edge that completed a handshake, re-present the queue head after it.
  logic [NS-1:0] fire;
  beat_t         src_b;
  initial begin
    in_tvalid = '0;
    in_tlast  = '0;
    in_tdata  = '0;
    in_tuser  = '0;
    forever begin
      @(negedge clk);
      fire = in_tvalid & in_tready;
      @(posedge clk);
      for (int i = 0; i < NS; i++) if (fire[i] && src_q[i].size() != 0) src_q[i].delete(0);
      #2;
      for (int i = 0; i < NS; i++) begin
        if (src_q[i].size() != 0 && !hold[i]) begin
          src_b            = src_q[i][0];
          in_tvalid[i]     = 1'b1;
          in_tlast[i]      = src_b.l;
          in_tdata[i*8+:8] = src_b.d;
          in_tuser[i]      = src_b.u;
        end else begin
          in_tvalid[i]     = 1'b0;
          in_tlast[i]      = 1'b0;
          in_tdata[i*8+:8] = 8'h00;
          in_tuser[i]      = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop per handshake, stability under backpressure, bubble after tlast.
  beat_t       mon_e;
  logic        pend;
  logic        after_last;
  logic [12:0] held;
  logic [12:0] cur;
  initial begin
    pend       = 1'b0;
    after_last = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      cur = {grant_valid, grant_index, o_tdata, o_tuser, o_tlast};
      if (pend) begin
        if (!o_tvalid) check("valid_dropped", 32'(o_tvalid), 32'd1);
        else           check("stable_bp", 32'(cur), 32'(held));
      end
      pend = o_tvalid && !o_tready;
      held = cur;
      if (after_last) check("bubble", 32'(o_tvalid), 32'd0);
      after_last = o_tvalid && o_tready && o_tlast;
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(cur), 32'h1fff);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 32'(cur), 32'({1'b1, mon_e.s, mon_e.d, mon_e.u, mon_e.l}));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sresetn  = 1'b0;
    o_tready = 1'b1;
    hold     = '0;

    // Reset then idle
    cyc();
    repeat (2) begin
      @(negedge clk);
      check("rst_gv", 32'(grant_valid), 32'd0);
      check("rst_ov", 32'(o_tvalid), 32'd0);
      check("rst_rdy", 32'(in_tready), 32'd0);
      cyc();
    end
    sresetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_gv", 32'(grant_valid), 32'd0);
      check("idle_ov", 32'(o_tvalid), 32'd0);
      cyc();
    end

    // Single requester on stream 1
    src_pkt(1, 3, 8'h11, 8'h11);
    exp_pkt(1, 3, 8'h11, 8'h11);
    @(negedge clk);
    check("arb_gv", 32'(grant_valid), 32'd0);
    check("arb_rdy", 32'(in_tready), 32'd0);
    @(negedge clk);
    check("lock_gi", 32'(grant_index), 32'd1);
    check("lock_rdy", 32'(in_tready), 32'b0010);
    wait_drain(20);
    @(negedge clk);
    check("ret_idle_gv", 32'(grant_valid), 32'd0);
    check("ret_idle_rdy", 32'(in_tready), 32'd0);
    cyc();

    // Round-robin with all four streams requesting
    reset_dut();
    src_pkt(0, 2, 8'h00, 8'h01);
    src_pkt(0, 2, 8'h02, 8'h01);
    src_pkt(1, 2, 8'h10, 8'h01);
    src_pkt(2, 2, 8'h20, 8'h01);
    src_pkt(3, 2, 8'h30, 8'h01);
    exp_pkt(0, 2, 8'h00, 8'h01);
    exp_pkt(1, 2, 8'h10, 8'h01);
    exp_pkt(2, 2, 8'h20, 8'h01);
    exp_pkt(3, 2, 8'h30, 8'h01);
    exp_pkt(0, 2, 8'h02, 8'h01);
    wait_drain(40);

    // Lock hold with backpressure; stream 2 arrives mid-packet
    reset_dut();
    src_pkt(0, 4, 8'hA0, 8'h01);
    exp_pkt(0, 4, 8'hA0, 8'h01);
    exp_pkt(2, 2, 8'hC0, 8'h01);
    cyc();
    src_pkt(2, 2, 8'hC0, 8'h01);
    cyc();
    o_tready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_rdy", 32'(in_tready), 32'd0);
      check("bp_gi", 32'(grant_index), 32'd0);
      check("bp_ov", 32'(o_tvalid), 32'd1);
      cyc();
    end
    o_tready = 1'b1;
    wait_drain(30);

    // Locked stream 1 stalls for 3 cycles while stream 0 waits
    src_pkt(1, 3, 8'h50, 8'h01);
    exp_pkt(1, 3, 8'h50, 8'h01);
    exp_pkt(0, 2, 8'h60, 8'h01);
    cyc();
    src_pkt(0, 2, 8'h60, 8'h01);
    cyc();
    hold[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_ov", 32'(o_tvalid), 32'd0);
      check("stall_gi", 32'(grant_index), 32'd1);
      check("stall_gv", 32'(grant_valid), 32'd1);
      check("stall_rdy", 32'(in_tready), 32'b0010);
      cyc();
    end
    hold[1] = 1'b0;
    wait_drain(30);

    // Reset on beat 2 of a 4-beat packet from stream 3
    src_pkt(3, 4, 8'h70, 8'h01);
    exp_q.push_back(mk(3, 8'h70, 1'b0));
    exp_q.push_back(mk(3, 8'h71, 1'b0));
    exp_pkt(0, 2, 8'h80, 8'h01);
    exp_pkt(3, 2, 8'h90, 8'h01);
    cyc();
    cyc();
    sresetn = 1'b0;
    cyc();
    sresetn = 1'b1;
    src_q[3].delete();
    src_pkt(0, 2, 8'h80, 8'h01);
    src_pkt(3, 2, 8'h90, 8'h01);
    @(negedge clk);
    check("rr_gv", 32'(grant_valid), 32'd0);
    check("rr_rdy", 32'(in_tready), 32'd0);
    check("rr_ov", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    check("rr_gv_lock", 32'(grant_valid), 32'd1);
    check("rr_gi", 32'(grant_index), 32'd0);
    wait_drain(30);

    cyc();
    check("exp_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares one AXI stream output between NUM_STREAMS input requesters.
- Grants whole packets using round-robin priority and holds the grant until the tlast beat completes.
- Sits on the merge side of the stream fabric, as the counterpart of the fan-out broadcaster/register path.
- Output signals are a combinational mux of the granted input; grant state is registered.

Parameters:
AXIS_BYTES, 1, tdata width in bytes per stream
AXIS_USER_BITS, 1, tuser width per stream
NUM_STREAMS, 2, number of input streams (>=1)

Ports:
clk  input  1  clock
sresetn  input  1  synchronous active-low reset
axis_i_tready  output  NUM_STREAMS  per-input ready
axis_i_tvalid  input  NUM_STREAMS  per-input valid
axis_i_tlast  input  NUM_STREAMS  per-input last
axis_i_tdata  input  NUM_STREAMS*AXIS_BYTES*8  packed data; stream i at [(i+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]
axis_i_tuser  input  NUM_STREAMS*AXIS_USER_BITS  packed user, same packing
axis_o_tready  input  1  output ready
axis_o_tvalid  output  1  output valid
axis_o_tlast  output  1  output last
axis_o_tdata  output  AXIS_BYTES*8  output data
axis_o_tuser  output  AXIS_USER_BITS  output user
grant_valid  output  1  high while a packet is locked
grant_index  output  IDX_W  index of locked stream; IDX_W = max(1, $clog2(NUM_STREAMS))

Behaviour:
- Clock and reset: single clock clk; sresetn is synchronous and active-low.
- Reset: state=IDLE, grant_index=0, priority pointer=0 (stream 0 highest). grant_valid=0. axis_o_tvalid=0. All axis_i_tready=0.
- States: IDLE, LOCKED.
- IDLE:
  - Outputs are idle: axis_o_tvalid=0 and all axis_i_tready=0.
  - If any axis_i_tvalid is high, choose the first valid index searching pointer, pointer+1, ..., wrapping modulo NUM_STREAMS.
  - Register that index into grant_index and go to LOCKED on the next edge.
  - If no input is valid, stay in IDLE.
- LOCKED, with g = grant_index:
  - axis_o_tvalid/tlast/tdata/tuser = input g fields.
  - axis_i_tready[g] = axis_o_tready; all other axis_i_tready = 0.
  - grant_valid = 1.
- Packet end: a beat with axis_o_tvalid & axis_o_tready & axis_o_tlast returns the block to IDLE and sets the pointer to (g+1) mod NUM_STREAMS.
- Latency: combinational pass-through while LOCKED. One IDLE arbitration cycle precedes every packet, so maximum throughput is L beats per L+1 cycles.
- Grant stability: the decision is only re-evaluated in IDLE. Input valid changes during LOCKED never change g.
  - A locked input dropping tvalid mid-packet stalls the output (tvalid=0) while the grant is held.
- Fairness: each requesting stream is granted within NUM_STREAMS packets.
- Single-beat packet (tlast on first beat): LOCKED lasts one cycle if the output is ready. The next grant decision is made in the following IDLE cycle.
- Backpressure: axis_o_tready=0 holds state, data and all input readys low.
- Pointer wrap: after stream NUM_STREAMS-1 the pointer wraps to 0.
- NUM_STREAMS=1: always grants stream 0; the 1-of-2-cycle bubble still applies.
- Reset mid-packet:
  - On the edge with sresetn=0, state forces to IDLE and the pointer to 0.
  - From the next cycle, all tready and tvalid outputs are 0.
  - The partial packet is abandoned; no recovery is attempted.
- AXI compliance:
  - axis_o_tvalid never depends on axis_o_tready.
  - Output fields stay stable while tvalid=1 and tready=0, provided the granted input obeys AXI.

Test Plan:
- Reset then idle: sresetn=0 for 2 cycles, all inputs invalid -> grant_valid=0, axis_o_tvalid=0, axis_i_tready=2'b00 throughout.
- Single requester: stream 1 sends 3-beat packet 0x11,0x22,0x33(tlast), output always ready -> grant_index=1 one cycle after tvalid rises; output beats 0x11,0x22,0x33 on consecutive cycles; axis_i_tready=2'b10 only during LOCKED; returns to IDLE.
- Round-robin contention: NUM_STREAMS=4, all streams continuously offer 2-beat packets -> grant order 0,1,2,3,0; each packet has exactly 2 output beats with one idle cycle between packets.
- Lock hold and backpressure: stream 0 locked; stream 2 becomes valid mid-packet; axis_o_tready toggles 1,0,0,1 -> grant_index stays 0 until stream 0's tlast handshake; data held stable during the ready=0 cycles; stream 2 granted next.
- Mid-packet stall: locked stream 1 drops tvalid for 3 cycles between beats while stream 0 is valid -> axis_o_tvalid=0 for those 3 cycles; grant stays 1; stream 0 is not served until stream 1's tlast.
- Reset mid-packet: assert sresetn=0 on beat 2 of a 4-beat packet from stream 3 -> the next cycle shows grant_valid=0 and all tready=0; after release, stream 0 has priority if both 0 and 3 are valid.
